decoder_5to32: RTL and testbench

DECODER_5TO32 -- requirements
Module: decoder_5to32

---
 rtl/decoder_5to32.sv | 46 ++++
 tb/tb_decoder_5to32.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/decoder_5to32.sv
// Registered 5-to-32 one-hot decoder built from a 2-to-4 bank select feeding four
// 3-to-8 stages; output clears asynchronously on reset.
module decoder_5to32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  IN,
    input  logic        EN,
    output logic [31:0] OUT
);

    logic [3:0]  bank_en;
    logic [31:0] out_d;
    logic [31:0] out_q;

    // 2-to-4 stage: IN[4:3] picks which 3-to-8 bank is enabled.
    always_comb begin
        bank_en = 4'b0000;
        if (EN) begin
            bank_en[IN[4:3]] = 1'b1;
        end
    end

    for (genvar j = 0; j < 4; j++) begin : g_bank
        logic [7:0] stage_out;

        always_comb begin
            stage_out = 8'h00;
            if (bank_en[j]) begin
                stage_out[IN[2:0]] = 1'b1;
            end
        end

        assign out_d[8*j +: 8] = stage_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= 32'h0000_0000;
        end else begin
            out_q <= out_d;
        end
    end

    assign OUT = out_q;

endmodule

// File: tb/tb_decoder_5to32.sv
// Scoreboard bench for decoder_5to32: the driver queues expected words from a
// power-of-two table, and a monitor compares them one clock later.
module tb_decoder_5to32;

    logic        clk;
    logic        rst_n;
    logic [4:0]  IN;
    logic        EN;
    logic [31:0] OUT;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] pow2[32];

    decoder_5to32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .IN    (IN),
        .EN    (EN),
        .OUT   (OUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_model(input logic [4:0] in, input logic en);
        if (!en) return 32'h0;
        return pow2[in];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive on the falling edge so the next rising edge captures the new inputs.
    task automatic drive(input logic [4:0] in, input logic en);
        @(negedge clk);
        IN = in;
        EN = en;
        exp_q.push_back(ref_model(in, en));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(posedge clk);
            #3;
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: the register updates every edge, so every edge with a pending entry is checked.
    always @(posedge clk) begin
        logic [31:0] e;
        #2;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("decode", OUT, e);
            if (e != 32'h0) begin
                check("popcount", 32'($countones(OUT)), 32'd1);
            end
        end
    end

    initial begin
        pow2[0] = 32'h1;
        for (int k = 1; k < 32; k++) pow2[k] = pow2[k-1] * 2;

        rst_n = 1'b0;
        EN    = 1'b1;
        IN    = 5'd7;
        #3;
        check("reset_async", OUT, 32'h0);
        repeat (3) @(posedge clk);
        #2;
        check("reset_hold_clk", OUT, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("deassert_no_change", OUT, 32'h0);

        for (int i = 0; i < 7; i++) drive(5'(i), 1'b1);
        drain();

        for (int i = 0; i < 32; i++) drive(5'(i), 1'b1);
        drain();
        check("in31", OUT, 32'h8000_0000);

        drive(5'd8, 1'b1);
        drain();
        check("in8_bank1", OUT, 32'h0000_0100);

        drive(5'd12, 1'b0);
        drain();
        check("en_low", OUT, 32'h0);
        drive(5'd12, 1'b1);
        drain();
        check("en_high", OUT, 32'h0000_1000);

        // IN changes between edges; OUT must hold until the next rising edge.
        drive(5'd3, 1'b1);
        drain();
        IN = 5'd20;
        #1;
        check("latency_hold", OUT, 32'h8);
        exp_q.push_back(ref_model(5'd20, 1'b1));
        drain();
        check("latency_update", OUT, 32'h0010_0000);

        // Asynchronous reset between edges.
        rst_n = 1'b0;
        IN    = 5'd1;
        EN    = 1'b1;
        #1;
        check("reset_mid", OUT, 32'h0);
        @(posedge clk);
        #2;
        check("reset_mid_clk", OUT, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_no_change", OUT, 32'h0);
        exp_q.push_back(ref_model(5'd1, 1'b1));
        drain();
        check("after_release", OUT, 32'h2);

        for (int i = 0; i < 60; i++) begin
            drive(5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
